// File: rtl/v_hier_drv.sv
// Pattern driver / response checker: steps avec through 0..NUM_VEC-1, samples qvec LATENCY clocks later,
// counts masked mismatches. Define V_HIER_DRV_ERRLOG_EN to add first-mismatch capture ports.
module v_hier_drv #(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      NUM_VEC  = 16,
  parameter int unsigned      LATENCY  = 2,
  parameter logic [WIDTH-1:0] EXP_XOR  = '0,
  parameter logic [WIDTH-1:0] CHK_MASK = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] avec,
  input  logic [WIDTH-1:0] qvec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count
`ifdef V_HIER_DRV_ERRLOG_EN
  ,
  output logic [WIDTH-1:0] first_err_vec,
  output logic [WIDTH-1:0] first_err_q
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0]     LAT_LAST = 4'(LATENCY - 1);
  localparam logic [WIDTH:0] IDX_LAST = (WIDTH + 1)'(NUM_VEC - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_wait;
  logic [WIDTH:0]   r_idx;
  logic [WIDTH-1:0] r_avec;
  logic             r_busy, r_done, r_pass;
  logic [7:0]       r_err;

  logic             w_sample, w_last, w_mism, w_hit;
  logic [7:0]       w_err_nxt;
  logic [WIDTH:0]   w_idx_inc;

  assign w_sample  = (r_state == S_RUN) && (r_wait == LAT_LAST);
  assign w_last    = w_sample && (r_idx == IDX_LAST);
  assign w_mism    = |((qvec ^ r_avec ^ EXP_XOR) & CHK_MASK);
  assign w_hit     = w_sample && w_mism;
  assign w_err_nxt = (w_hit && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
  assign w_idx_inc = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef V_HIER_DRV_ERRLOG_EN
  logic             r_logged;
  logic [WIDTH-1:0] r_fe_vec, r_fe_q;

  // A separate flag is needed: a legitimate first mismatch can be at avec==0 with qvec==0 masked bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_logged <= 1'b0;
      r_fe_vec <= '0;
      r_fe_q   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_logged <= 1'b0;
      r_fe_vec <= '0;
      r_fe_q   <= '0;
    end else if (w_hit && !r_logged) begin
      r_logged <= 1'b1;
      r_fe_vec <= r_avec;
      r_fe_q   <= qvec;
    end
  end

  assign first_err_vec = r_fe_vec;
  assign first_err_q   = r_fe_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_idx  <= '0;
      r_avec <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wait <= '0;
            r_idx  <= '0;
            r_avec <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        S_RUN: begin
          r_err <= w_err_nxt;
          if (w_sample) begin
            r_wait <= '0;
            if (!w_last) begin
              r_idx  <= w_idx_inc;
              r_avec <= w_idx_inc[WIDTH-1:0];
            end else begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_pass <= (w_err_nxt == 8'd0);
              r_avec <= '0;
            end
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_DONE:  r_done <= 1'b0;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign avec      = r_avec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

endmodule

// File: tb/tb_v_hier_drv.sv
// Self-checking bench for v_hier_drv: four instances covering loopback/random corruption,
// mask+xor, latency-1 wrap runs and 8-bit saturation.
module tb_v_hier_drv;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] start_v;
  always #5 clk = ~clk;

  logic [3:0] avec0, qvec0, pipe0, avec1, qvec1, pipe1, avec2, qvec2;
  logic [7:0] avec3, qvec3;
  logic [7:0] err0, err1, err2, err3;
  logic [3:0] busy_m, done_m, pass_m;
  logic [3:0] corr0 [16];
  logic [3:0] corr1 [16];

`ifdef V_HIER_DRV_ERRLOG_EN
  logic [3:0] fev0, feq0, fev1, feq1, fev2, feq2;
  logic [7:0] fev3, feq3;
`endif

  // Responder for u0/u1: one register stage, with per-vector corruption from the bench tables.
  always_ff @(posedge clk) begin
    pipe0 <= avec0;
    pipe1 <= avec1;
  end
  assign qvec0 = pipe0 ^ corr0[pipe0];
  assign qvec1 = ((pipe1 ^ 4'h5) | 4'h8) ^ corr1[pipe1];
  assign qvec2 = ~avec2;
  assign qvec3 = ~avec3;

  v_hier_drv #(.WIDTH(4), .NUM_VEC(16), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .avec(avec0), .qvec(qvec0),
    .busy(busy_m[0]), .done(done_m[0]), .pass(pass_m[0]), .err_count(err0)
`ifdef V_HIER_DRV_ERRLOG_EN
    , .first_err_vec(fev0), .first_err_q(feq0)
`endif
  );
  v_hier_drv #(.WIDTH(4), .NUM_VEC(16), .LATENCY(2), .EXP_XOR(4'h5), .CHK_MASK(4'h3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .avec(avec1), .qvec(qvec1),
    .busy(busy_m[1]), .done(done_m[1]), .pass(pass_m[1]), .err_count(err1)
`ifdef V_HIER_DRV_ERRLOG_EN
    , .first_err_vec(fev1), .first_err_q(feq1)
`endif
  );
  v_hier_drv #(.WIDTH(4), .NUM_VEC(16), .LATENCY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .avec(avec2), .qvec(qvec2),
    .busy(busy_m[2]), .done(done_m[2]), .pass(pass_m[2]), .err_count(err2)
`ifdef V_HIER_DRV_ERRLOG_EN
    , .first_err_vec(fev2), .first_err_q(feq2)
`endif
  );
  v_hier_drv #(.WIDTH(8), .NUM_VEC(256), .LATENCY(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .avec(avec3), .qvec(qvec3),
    .busy(busy_m[3]), .done(done_m[3]), .pass(pass_m[3]), .err_count(err3)
`ifdef V_HIER_DRV_ERRLOG_EN
    , .first_err_vec(fev3), .first_err_q(feq3)
`endif
  );

  logic [7:0] avec_m [4];
  logic [7:0] err_m  [4];
  assign avec_m[0] = {4'h0, avec0};
  assign avec_m[1] = {4'h0, avec1};
  assign avec_m[2] = {4'h0, avec2};
  assign avec_m[3] = avec3;
  assign err_m[0]  = err0;
  assign err_m[1]  = err1;
  assign err_m[2]  = err2;
  assign err_m[3]  = err3;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: u0 mismatches wherever the injected corruption is nonzero.
  function automatic int model_err0();
    int c = 0;
    for (int k = 0; k < 16; k++) if (corr0[k] != 4'h0) c++;
    return c;
  endfunction

  // Model: u1 compares only bits [1:0], so corruption elsewhere (and the forced bit 3) is invisible.
  function automatic int model_err1();
    int c = 0;
    for (int k = 0; k < 16; k++) if ((corr1[k] & 4'h3) != 4'h0) c++;
    return c;
  endfunction

  task automatic run(input int s, input int lat, input int nvec, input int wbits,
                     input bit mid, input int exp_err);
    int n;
    bit seq_ok;
    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v[s] = 1'b0;
    check("busy_after_start", busy_m[s], 1);
    check("avec_after_start", avec_m[s], 0);
    n = 0;
    seq_ok = 1'b1;
    while (!done_m[s] && n < nvec * lat + 20) begin
      if (busy_m[s] !== 1'b1 || avec_m[s] !== 8'((n / lat) % (1 << wbits))) seq_ok = 1'b0;
      if (mid && n == 10) start_v[s] = 1'b1;
      if (mid && n == 11) start_v[s] = 1'b0;
      @(negedge clk); n++;
    end
    check("done_cycle", n, nvec * lat);
    check("avec_seq", seq_ok, 1);
    check("busy_at_done", busy_m[s], 0);
    check("err_count", err_m[s], exp_err);
    check("pass", pass_m[s], (exp_err == 0) ? 1 : 0);
    check("avec_at_done", avec_m[s], 0);
    @(negedge clk);
    check("done_width", done_m[s], 0);
    check("no_restart", busy_m[s], 0);
  endtask

  task automatic check_first_err0();
`ifdef V_HIER_DRV_ERRLOG_EN
    logic [3:0] ev, eq;
    ev = 4'h0;
    eq = 4'h0;
    for (int k = 15; k >= 0; k--) begin
      if (corr0[k] != 4'h0) begin
        ev = 4'(k);
        eq = 4'(k) ^ corr0[k];
      end
    end
    check("first_err_vec", fev0, ev);
    check("first_err_q", feq0, eq);
`endif
  endtask

  initial begin
    bit saw_done;
    rst_n   = 1'b0;
    start_v = '0;
    for (int k = 0; k < 16; k++) begin
      corr0[k] = 4'h0;
      corr1[k] = 4'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy_m[0], 0);
    check("rst_done", done_m[0], 0);
    check("rst_pass", pass_m[0], 0);
    check("rst_err", err0, 0);
    check("rst_avec", avec0, 0);
    rst_n = 1'b1;

    run(0, 2, 16, 4, 1'b0, model_err0());
    check_first_err0();

    for (int k = 0; k < 16; k++) corr0[k] = 4'(k) & 4'h2;
    run(0, 2, 16, 4, 1'b0, model_err0());
    check_first_err0();

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++)
        corr0[k] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      run(0, 2, 16, 4, (r == 1), model_err0());
      check_first_err0();
    end

    run(1, 2, 16, 4, 1'b0, model_err1());
    for (int k = 0; k < 16; k++)
      corr1[k] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    run(1, 2, 16, 4, 1'b0, model_err1());

    for (int r = 0; r < 3; r++) run(2, 1, 16, 4, 1'b0, 16);

    run(3, 1, 256, 8, 1'b0, 255);

    for (int k = 0; k < 16; k++) corr0[k] = 4'hF;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("err_before_reset", (err0 != 8'd0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_avec", avec0, 0);
    check("midrst_busy", busy_m[0], 0);
    check("midrst_err", err0, 0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_m[0] || busy_m[0]) saw_done = 1'b1;
    end
    check("idle_after_reset", saw_done, 0);
    check("idle_avec", avec0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
